toggle_cover_detect: RTL and testbench
======================================

# toggle_cover_detect

Edge-detection front end for the toggle-coverage instrumentation. It samples a vector of monitored design signals and detects rising and falling transitions on each bit. It emits a registered one-cycle pulse vector in rise/fall-interleaved order, and that vector drives the `valid` input of the downstream `GEN_w<N>_toggle` reporting module. It also keeps a sticky covered bitmap and a running covered-point count for on-line progress monitoring.

## Interface
- `WIDTH`, 21: number of monitored signals; the pulse vector is 2*WIDTH bits (42 by default).
- `SETTLE_CYCLES`, 2: cycles after reset or `clear` during which edges are ignored; legal range 1..15.
- `clock` input 1: clock.
- `reset` input 1: reset, synchronous, active-low.
- `en` input 1: detection enable; when low, edges are not reported but `prev` still tracks `sig`.
- `clear` input 1: one-cycle request; zeroes the covered bitmap and count and re-enters SETTLE.
- `sig` input WIDTH: monitored signals, sampled every cycle.
- `valid` output 2*WIDTH: bit 2i = rise of `sig[i]`, bit 2i+1 = fall of `sig[i]`; one-cycle pulses.
- `covered` output 2*WIDTH: sticky bitmap of points toggled since reset or the last `clear`.
- `covered_count` output $clog2(2*WIDTH+1): popcount of `covered`.
- `all_covered` output 1: high when `covered_count` == 2*WIDTH.
- `armed` output 1: high in state ARMED.

## Operation
- `prev` register, WIDTH bits: loads `sig` every cycle in every state, including during reset.
- Detection for each i:
  - rise_i = ~prev[i] & sig[i]
  - fall_i = prev[i] & ~sig[i]
  - raw[2i] = rise_i, raw[2i+1] = fall_i
- FSM states: SETTLE, ARMED.
  - Reset or `clear` → SETTLE, with the settle counter loaded to SETTLE_CYCLES-1.
  - SETTLE: the counter decrements each cycle; when it reaches 0 the FSM goes to ARMED on the next edge.
  - ARMED: stays until reset or `clear`.
- Report condition: hit = raw & {2*WIDTH{armed & en}}, gated further by the TOGGLE_ONCE_EN mask.
- `covered` update: covered <= covered | hit. `covered_count` is recomputed from the next-state bitmap, so it is never stale against `covered`.
- `covered_count` cannot exceed 2*WIDTH, so no saturation logic is needed.
- Reset values:
  - `valid`, `covered`, `covered_count` = 0.
  - `all_covered` = 0, `armed` = 0.
  - `prev` = `sig` as sampled at that edge.
- Boundary cases:
  - `clear` together with an edge: `clear` wins. `valid` = 0 for that cycle, the bitmap becomes 0, and the FSM enters SETTLE.
  - Reset asserted mid-ARMED: on the next edge all state and outputs return to their reset values and the FSM enters SETTLE.
  - `en` deasserted in ARMED: edges during that time are lost and never reported later. Re-enabling does not produce a stale edge because `prev` kept tracking `sig`.
  - A bit that toggles every cycle produces a pulse every cycle when TOGGLE_ONCE_EN is undefined.

## Timing
- Latency: an edge present on `sig` at cycle t, against `prev` holding the t-1 value, appears on `valid` at cycle t+1. This path is registered.
- `covered`, `covered_count` and `all_covered` update on the same edge as `valid`.
- `armed` rises exactly SETTLE_CYCLES cycles after the deasserting reset edge or the `clear` edge. The first reportable edge is the one sampled in the first ARMED cycle.
- Throughput: one full vector every cycle. There is no backpressure, because the downstream reporter consumes unconditionally.

## Configuration
- `TOGGLE_ONCE_EN` defined: hit additionally masks with ~covered. Each point pulses `valid` at most once between clears, which bounds the downstream DPI call rate.
- `TOGGLE_ONCE_EN` undefined: every qualifying edge pulses `valid`.
- `covered`, `covered_count` and `all_covered` behave identically in both builds.

## Test plan
- Reset low for 3 cycles with `sig`=21'h0, release with `en`=1 and SETTLE_CYCLES=2 → `armed`=0 for 2 cycles then 1; all outputs 0 throughout.
- Once armed, drive `sig[0]` 0→1 at cycle t → `valid`=42'h1 at t+1 only, `covered_count`=1. Then drive `sig[0]` 1→0 → `valid`=42'h2, `covered_count`=2.
- Toggle `sig[5]` 0→1→0→1 on consecutive cycles:
  - With TOGGLE_ONCE_EN: `valid[10]` and `valid[11]` pulse once each, and `covered_count` ends at 2.
  - Without TOGGLE_ONCE_EN: 3 pulses total, and `covered_count` still ends at 2.
- `sig` alternates between 21'h0 and 21'h1FFFFF → `all_covered`=1 after the second transition.
  - Then assert `clear` in the same cycle as an edge → `valid`=0, `covered_count`=0, `armed`=0.
  - `armed` returns to 1 after 2 cycles.
- `en`=0 while `sig[3]` rises, then `en`=1 with `sig[3]` held at 1 → no `valid[6]` pulse ever appears, and `covered[6]`=0.
- Assert reset mid-ARMED with `covered_count`=7 → on the next edge every output is 0 and `armed`=0. A toggle during SETTLE is not reported.

Source files
------------

// File: rtl/toggle_cover_detect.sv
// Purpose: per-bit rise/fall edge detector for toggle coverage, with sticky covered bitmap and count.
// Latency: edge sampled at cycle t appears on valid (and covered/count) at cycle t+1, fully registered.
// Backpressure: none; one full pulse vector per cycle, the downstream reporter always consumes.
// Optional build macro: TOGGLE_ONCE_EN -- each point pulses valid at most once between clears.
module toggle_cover_detect #(
  parameter int WIDTH         = 21,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             en,
  input  logic                             clear,
  input  logic [WIDTH-1:0]                 sig,
  output logic [2*WIDTH-1:0]               valid,
  output logic [2*WIDTH-1:0]               covered,
  output logic [$clog2(2*WIDTH+1)-1:0]     covered_count,
  output logic                             all_covered,
  output logic                             armed
);

  localparam int              PW          = 2 * WIDTH;
  localparam int              CW          = $clog2(PW + 1);
  localparam logic [3:0]      SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]   FULL_COUNT  = CW'(PW);

  typedef enum logic {
    SETTLE = 1'b0,
    ARMED  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [3:0]      settle_cnt;
  logic [3:0]      settle_cnt_next;
  logic [WIDTH-1:0] prev;
  logic [PW-1:0]   raw;
  logic [PW-1:0]   hit;
  logic [PW-1:0]   covered_next;
  logic [CW-1:0]   count_next;

  // prev follows sig every cycle, reset included, so no stale edge survives reset or en-low periods
  always_ff @(posedge clock) begin
    prev <= sig;
  end

  // Raw edges, interleaved: even bit = rise, odd bit = fall
  always_comb begin
    raw = '0;
    for (int i = 0; i < WIDTH; i++) begin
      raw[2*i]   = ~prev[i] &  sig[i];
      raw[2*i+1] =  prev[i] & ~sig[i];
    end
  end

  // FSM state and settle counter registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= SETTLE;
      settle_cnt <= SETTLE_INIT;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
    end
  end

  // Next-state: count down in SETTLE, then hold ARMED until clear restarts the settle window
  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    case (state)
      SETTLE: begin
        if (settle_cnt == 4'd0) begin
          state_next = ARMED;
        end else begin
          settle_cnt_next = settle_cnt - 4'd1;
        end
      end
      ARMED: begin
        state_next = ARMED;
      end
      default: begin
        state_next = SETTLE;
      end
    endcase
    if (clear) begin
      state_next      = SETTLE;
      settle_cnt_next = SETTLE_INIT;
    end
  end

  assign armed = (state == ARMED);

  // Qualify edges and build the next covered bitmap; clear dominates any coincident edge
  always_comb begin
    hit = raw & {PW{armed & en}};
`ifdef TOGGLE_ONCE_EN
    hit = hit & ~covered;
`endif
    covered_next = clear ? '0 : (covered | hit);
  end

  // Popcount of the next bitmap so the count register never lags covered
  always_comb begin
    count_next = '0;
    for (int i = 0; i < PW; i++) begin
      count_next = count_next + CW'(covered_next[i]);
    end
  end

  // Registered outputs, all updated on the same edge
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid         <= '0;
      covered       <= '0;
      covered_count <= '0;
      all_covered   <= 1'b0;
    end else begin
      valid         <= clear ? '0 : hit;
      covered       <= covered_next;
      covered_count <= count_next;
      all_covered   <= (count_next == FULL_COUNT);
    end
  end

endmodule

// File: tb/tb_toggle_cover_detect.sv
// Directed bench for toggle_cover_detect: expected outputs are queued as each step is driven
// and popped for comparison one clock later. Expectations differ with TOGGLE_ONCE_EN where noted.
module tb_toggle_cover_detect;

  logic        clock;
  logic        reset;
  logic        en;
  logic        clear;
  logic [20:0] sig;
  logic [41:0] valid;
  logic [41:0] covered;
  logic [5:0]  covered_count;
  logic        all_covered;
  logic        armed;

  localparam logic [41:0] EVEN = 42'h155_5555_5555;
  localparam logic [41:0] ODD  = 42'h2AA_AAAA_AAAA;
  localparam logic [41:0] ALL  = 42'h3FF_FFFF_FFFF;

  typedef struct packed {
    logic [41:0] v;
    logic [41:0] cov;
    logic [5:0]  cnt;
    logic        ac;
    logic        arm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  toggle_cover_detect #(.WIDTH(21), .SETTLE_CYCLES(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .en            (en),
    .clear         (clear),
    .sig           (sig),
    .valid         (valid),
    .covered       (covered),
    .covered_count (covered_count),
    .all_covered   (all_covered),
    .armed         (armed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the expectation for the inputs now applied, clock once, then pop and compare
  task automatic step(input string tag, input logic [41:0] v, input logic [41:0] cov,
                      input logic [5:0] cnt, input logic ac, input logic arm);
    exp_t e;
    e.v = v; e.cov = cov; e.cnt = cnt; e.ac = ac; e.arm = arm;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk({tag, ".valid"},         64'(valid),         64'(e.v));
    chk({tag, ".covered"},       64'(covered),       64'(e.cov));
    chk({tag, ".covered_count"}, 64'(covered_count), 64'(e.cnt));
    chk({tag, ".all_covered"},   64'(all_covered),   64'(e.ac));
    chk({tag, ".armed"},         64'(armed),         64'(e.arm));
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; clear = 1'b0; sig = 21'h0;

    // Reset held three cycles, then two settle cycles before armed
    step("rst0", 42'h0, 42'h0, 6'd0, 1'b0, 1'b0);
    step("rst1", 42'h0, 42'h0, 6'd0, 1'b0, 1'b0);
    step("rst2", 42'h0, 42'h0, 6'd0, 1'b0, 1'b0);
    reset = 1'b1;
    step("settle1", 42'h0, 42'h0, 6'd0, 1'b0, 1'b0);
    step("settle2", 42'h0, 42'h0, 6'd0, 1'b0, 1'b1);

    // sig[0] rise then fall, then a quiet cycle
    sig = 21'h1;
    step("rise0", 42'h1, 42'h1, 6'd1, 1'b0, 1'b1);
    sig = 21'h0;
    step("fall0", 42'h2, 42'h3, 6'd2, 1'b0, 1'b1);
    step("quiet0", 42'h0, 42'h3, 6'd2, 1'b0, 1'b1);

    // sig[5] toggling on consecutive cycles
    sig = 21'h20;
    step("s5_r1", 42'h400, 42'h403, 6'd3, 1'b0, 1'b1);
    sig = 21'h0;
    step("s5_f1", 42'h800, 42'hC03, 6'd4, 1'b0, 1'b1);
    sig = 21'h20;
`ifdef TOGGLE_ONCE_EN
    step("s5_r2", 42'h0, 42'hC03, 6'd4, 1'b0, 1'b1);
`else
    step("s5_r2", 42'h400, 42'hC03, 6'd4, 1'b0, 1'b1);
`endif

    // Full-vector alternation to reach all_covered
    sig = 21'h1FFFFF;
`ifdef TOGGLE_ONCE_EN
    step("all_up", 42'h155_5555_5154, 42'h155_5555_5D57, 6'd23, 1'b0, 1'b1);
`else
    step("all_up", EVEN & ~42'h400, 42'h155_5555_5D57, 6'd23, 1'b0, 1'b1);
`endif
    sig = 21'h0;
`ifdef TOGGLE_ONCE_EN
    step("all_dn", 42'h2AA_AAAA_A2A8, ALL, 6'd42, 1'b1, 1'b1);
`else
    step("all_dn", ODD, ALL, 6'd42, 1'b1, 1'b1);
`endif

    // clear together with an edge wins; edge during settle is dropped
    sig = 21'h1FFFFF; clear = 1'b1;
    step("clear_edge", 42'h0, 42'h0, 6'd0, 1'b0, 1'b0);
    clear = 1'b0; sig = 21'h0;
    step("clear_settle", 42'h0, 42'h0, 6'd0, 1'b0, 1'b0);
    step("clear_rearm", 42'h0, 42'h0, 6'd0, 1'b0, 1'b1);

    // en low while sig[3] rises: edge lost, no stale pulse on re-enable
    en = 1'b0; sig = 21'h8;
    step("en_off", 42'h0, 42'h0, 6'd0, 1'b0, 1'b1);
    en = 1'b1;
    step("en_on1", 42'h0, 42'h0, 6'd0, 1'b0, 1'b1);
    step("en_on2", 42'h0, 42'h0, 6'd0, 1'b0, 1'b1);

    // Build covered_count = 7, then reset mid-ARMED
    sig = 21'h7;
    step("cnt4", 42'h95, 42'h95, 6'd4, 1'b0, 1'b1);
    sig = 21'h0;
    step("cnt7", 42'h2A, 42'hBF, 6'd7, 1'b0, 1'b1);
    reset = 1'b0; sig = 21'h8;
    step("mid_rst", 42'h0, 42'h0, 6'd0, 1'b0, 1'b0);
    reset = 1'b1; sig = 21'h0;
    step("rst_settle", 42'h0, 42'h0, 6'd0, 1'b0, 1'b0);
    step("rst_rearm", 42'h0, 42'h0, 6'd0, 1'b0, 1'b1);
    step("rst_quiet", 42'h0, 42'h0, 6'd0, 1'b0, 1'b1);
    sig = 21'h1;
    step("rst_rise0", 42'h1, 42'h1, 6'd1, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
